// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with guard interval and frame-synchronous data swap.
// Optional leading-zero suppression: define LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 50
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [3:0]                    hex_digit,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GUARD_LAST = DW'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {S_GUARD, S_ON} state_t;
  localparam state_t S_RESET = (GUARD_CYCLES == 0) ? S_ON : S_GUARD;

  state_t                  state, state_next;
  logic [DW-1:0]           div_cnt, div_next;
  logic [IW-1:0]           idx_next;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_next;
  logic [4*NUM_DIGITS-1:0] frame_reg, frame_next;
  logic                    pending, pending_next;
  logic                    slot_end, wrap;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic [3:0]              hex_next;

  always_comb begin
    slot_end = (div_cnt == DIV_LAST);
    wrap     = slot_end && (digit_idx == IDX_LAST);
    div_next = slot_end ? '0 : div_cnt + 1'b1;
    if (wrap)          idx_next = '0;
    else if (slot_end) idx_next = digit_idx + 1'b1;
    else               idx_next = digit_idx;
  end

  // A load on the wrap cycle bypasses the shadow so the new value shows without a frame of delay.
  always_comb begin
    shadow_next  = load ? digits_in : shadow;
    frame_next   = frame_reg;
    pending_next = pending;
    if (wrap) begin
      if (load)         frame_next = digits_in;
      else if (pending) frame_next = shadow;
      pending_next = 1'b0;
    end else if (load) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_GUARD: if (div_cnt == GUARD_LAST) state_next = S_ON;
      S_ON:    if (slot_end && (GUARD_CYCLES != 0)) state_next = S_GUARD;
      default: state_next = S_RESET;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the most significant digit down; a digit stays dark until a nonzero one is seen.
  always_comb begin
    logic nz_seen;
    lz_dark = '0;
    nz_seen = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (frame_next[4*(NUM_DIGITS-1-k) +: 4] != 4'h0) nz_seen = 1'b1;
      if (k != NUM_DIGITS - 1) lz_dark[NUM_DIGITS-1-k] = !nz_seen;
    end
  end
`else
  always_comb lz_dark = '0;
`endif

  always_comb begin
    anode_next = '1;
    if (state_next == S_ON && !blank_mask[idx_next] && !lz_dark[idx_next])
      anode_next[idx_next] = 1'b0;
    hex_next = frame_next[4*idx_next +: 4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      digit_idx   <= '0;
      shadow      <= '0;
      frame_reg   <= '0;
      pending     <= 1'b0;
      hex_digit   <= '0;
      anode       <= '1;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      digit_idx   <= idx_next;
      shadow      <= shadow_next;
      frame_reg   <= frame_next;
      pending     <= pending_next;
      hex_digit   <= hex_next;
      anode       <= anode_next;
      frame_start <= wrap;
    end
  end

endmodule
